// File: rtl/pp_norm_pkg.sv
// Shared types and helpers for the RGB888 normalisation stream.
package pp_norm_pkg;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  localparam int LANES      = 8;
  localparam int PHASE_STEP = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Channel index (p + step) mod 3; used for lane channel and per-word phase advance.
  function automatic logic [1:0] phase_add(input logic [1:0] p, input int step);
    int s;
    s = (int'(p) + step) % 3;
    return 2'(s);
  endfunction

  function automatic logic [7:0] sat8(input logic signed [17:0] v);
    if (v > 18'sd127) return 8'h7F;
    if (v < -18'sd128) return 8'h80;
    return v[7:0];
  endfunction

endpackage

// File: rtl/pp_norm_lane.sv
// One byte lane: S1 capture/select, S2 multiply, S3 shift + saturate.
module pp_norm_lane
  import pp_norm_pkg::*;
#(
  parameter int SHIFT = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [7:0]      pix,
  input  logic [1:0]      ch,
  input  logic [2:0][7:0] mean,
  input  logic [2:0][7:0] scale,
  output logic [7:0]      res
);

  logic [7:0]         pix1, mean1, scale1, mean_sel, scale_sel;
  logic signed [8:0]  d1;
  logic signed [17:0] d_ext, s_ext, p2, q2;

  always_comb begin
    mean_sel  = mean[CH_R];
    scale_sel = scale[CH_R];
    case (ch)
      CH_G: begin mean_sel = mean[CH_G]; scale_sel = scale[CH_G]; end
      CH_B: begin mean_sel = mean[CH_B]; scale_sel = scale[CH_B]; end
      default: ;
    endcase
  end

  assign d1    = $signed({1'b0, pix1}) - $signed({1'b0, mean1});
  assign d_ext = {{9{d1[8]}}, d1};
  assign s_ext = {10'd0, scale1};
  // |d*scale| <= 65025, so the low 18 bits of the product are exact.
  assign q2    = p2 >>> SHIFT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix1   <= '0;
      mean1  <= '0;
      scale1 <= '0;
      p2     <= '0;
      res    <= '0;
    end else if (en) begin
      pix1   <= pix;
      mean1  <= mean_sel;
      scale1 <= scale_sel;
      p2     <= d_ext * s_ext;
      res    <= sat8(q2);
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_norm_stream.sv
// Frame-controlled FIFO-to-FIFO normaliser: 8 byte lanes, 3-stage stallable pipeline.
module pp_pipeline_accel_norm_stream
  import pp_norm_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 24,
  parameter int SHIFT      = 7
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic [7:0]            mean_r,
  input  logic [7:0]            mean_g,
  input  logic [7:0]            mean_b,
  input  logic [7:0]            scale_r,
  input  logic [7:0]            scale_g,
  input  logic [7:0]            scale_b,
  input  logic                  in_empty_n,
  output logic                  in_read,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  out_full_n,
  output logic                  out_write,
  output logic [DATA_WIDTH-1:0] out_din
);

  localparam int STAGES = 3;

  state_t               state;
  logic [CNT_WIDTH-1:0] num_lat, rd_cnt, wr_cnt, rd_nxt, wr_nxt;
  logic [2:0][7:0]      mean_lat, scale_lat;
  logic [1:0]           phase;
  logic [STAGES:1]      vld_pipe;
  logic                 en;

  // Only a valid word blocked at the output can stall; bubbles never do.
  assign en        = ~(vld_pipe[STAGES] & ~out_full_n);
  assign rd_nxt    = rd_cnt + CNT_WIDTH'(1);
  assign wr_nxt    = wr_cnt + CNT_WIDTH'(1);
  assign in_read   = (state == RUN) & in_empty_n & en & (rd_cnt < num_lat);
  assign ap_ready  = in_read & (rd_nxt == num_lat);
  assign out_write = vld_pipe[STAGES] & out_full_n;
  assign ap_idle   = (state == IDLE);
  assign ap_done   = (state == DONE);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      num_lat   <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      mean_lat  <= '0;
      scale_lat <= '0;
      phase     <= '0;
      vld_pipe  <= '0;
    end else begin
      if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_read};
      case (state)
        IDLE: if (ap_start) begin
          num_lat   <= num_words;
          mean_lat  <= {mean_b, mean_g, mean_r};
          scale_lat <= {scale_b, scale_g, scale_r};
          rd_cnt    <= '0;
          wr_cnt    <= '0;
          phase     <= '0;
          state     <= (num_words == '0) ? DONE : RUN;
        end
        RUN: begin
          if (in_read) begin
            rd_cnt <= rd_nxt;
            phase  <= phase_add(phase, PHASE_STEP);
          end
          if (out_write) begin
            wr_cnt <= wr_nxt;
            if (wr_nxt == num_lat) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pp_norm_lane #(.SHIFT(SHIFT)) u_lane (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .en    (en),
      .pix   (in_dout[8*k +: 8]),
      .ch    (phase_add(phase, k)),
      .mean  (mean_lat),
      .scale (scale_lat),
      .res   (out_din[8*k +: 8])
    );
  end

endmodule
